// File: rtl/rr_mux_pkg.sv
// Shared types and default sizing for the rr_mux output-register multiplexer.
package rr_mux_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: one-hot grant to the first request found above ptr.
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  input  logic                    en,
  output logic [N_CH-1:0]         grant
);
  localparam int PW = $clog2(N_CH);

  logic [PW-1:0] idx;
  logic          found;

  // Offsets 1..N_CH visit ptr+1 first and ptr itself last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = PW'((int'(ptr) + k) % N_CH);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_mux.sv
// N_CH-to-1 mux into a single output register, fixed-select or round-robin.
// Optional transfer counter port enabled by macro RR_MUX_XFER_CNT_EN.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  input  logic [$clog2(N_CH)-1:0] sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                    out_ready
`ifdef RR_MUX_XFER_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);
  localparam int PW = $clog2(N_CH);

  state_t            state, state_nx;
  logic [PW-1:0]     ptr;
  logic              free;
  logic [N_CH-1:0]   rr_grant, fix_grant;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [WIDTH-1:0]  gnt_data;

  // Reset blocks grants so nothing is accepted that the reset would then drop.
  assign free      = !reset && ((state == EMPTY) || out_ready);
  assign out_valid = (state == FULL);

  always_comb begin
    fix_grant = '0;
    if (!mode && free && (int'(sel) < N_CH) && in_valid[sel])
      fix_grant[sel] = 1'b1;
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .en    (free && mode),
    .grant (rr_grant)
  );

  assign in_ready = mode ? rr_grant : fix_grant;
  assign gnt_any  = |in_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (in_ready[i]) gnt_idx = PW'(i);
  end

  assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (gnt_any) state_nx = FULL;
      FULL:    if (out_ready && !gnt_any) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  // ptr starts at N_CH-1 so the first round-robin search begins at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
      ptr      <= PW'(N_CH - 1);
    end else if (gnt_any) begin
      out_data <= gnt_data;
      out_ch   <= gnt_idx;
      if (mode) ptr <= gnt_idx;
    end
  end

`ifdef RR_MUX_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      xfer_cnt <= '0;
    else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF))
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rr_mux.sv
// Directed table-driven bench for rr_mux (N_CH=4, WIDTH=8) plus corner sequences.
module tb_rr_mux;
  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef RR_MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DATA = {8'hD3, 8'hA5, 8'h71, 8'h4E};

  rr_mux #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef RR_MUX_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [3:0] v;
    logic       ord;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ord);
    @(negedge clk);
    mode = m; sel = s; in_valid = v; out_ready = ord;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_data = DATA; mode = 1'b0; sel = '0; out_ready = 1'b0;

    //            m   s     v        ord   rdy      ov    ch    d
    tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h4E};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h71};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h4E};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h4E};
    tbl[6]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[7]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[8]  = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h71};
    tbl[9]  = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[10] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h4E};
    tbl[11] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h71};
    tbl[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[14] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ch", 64'(out_ch), 64'h0);
`ifdef RR_MUX_XFER_CNT_EN
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].ord);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        chk($sformatf("v%0d_out_ch", i), 64'(out_ch), 64'(tbl[i].exp_ch));
        chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(tbl[i].exp_d));
      end
    end

    // backpressure: hold 3C for 5 cycles with all channels requesting
    in_data[15:8] = 8'h3C;
    drive(1'b0, 2'd1, 4'b0010, 1'b1);
    @(posedge clk); #1;
    chk("bp_load_data", 64'(out_data), 64'h3C);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      #1;
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'h0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_data", c), 64'(out_data), 64'h3C);
      chk($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'h1);
    end
    in_data = DATA;

    // wrap-around from ptr=3 after reset, then ptr must be 1
    drive(1'b1, 2'd0, 4'b0000, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("wrap_rst_out_valid", 64'(out_valid), 64'h0);
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    reset = 1'b0;
    #1;
    chk("wrap_in_ready", 64'(in_ready), 64'b0010);
    @(posedge clk); #1;
    chk("wrap_out_ch", 64'(out_ch), 64'd1);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    #1;
    chk("wrap_next_in_ready", 64'(in_ready), 64'b0100);
    @(posedge clk); #1;
    chk("wrap_next_out_ch", 64'(out_ch), 64'd2);

    // reset while FULL discards data; channel 0 wins next
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_data", 64'(out_data), 64'h0);
    chk("midrst_out_ch", 64'(out_ch), 64'h0);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_grant", 64'(in_ready), 64'b0001);
    @(posedge clk); #1;
    chk("midrst_next_ch", 64'(out_ch), 64'd0);
    chk("midrst_next_data", 64'(out_data), 64'h4E);

`ifdef RR_MUX_XFER_CNT_EN
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("cnt_clear", 64'(xfer_cnt), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70001) @(posedge clk);
    #1;
    chk("cnt_saturate", 64'(xfer_cnt), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: data bits per channel, 1..64.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  N_CH  bit i high means channel i offers data.
REQ-006 SHALL have port in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_ready  output  N_CH  one-hot grant; channel i transfers when in_valid[i] and in_ready[i] are both high.
REQ-008 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-009 SHALL have port sel  input  $clog2(N_CH)  channel used in fixed mode.
REQ-010 SHALL have port out_valid  output  1  output register holds data.
REQ-011 SHALL have port out_data  output  WIDTH  registered data.
REQ-012 SHALL have port out_ch  output  $clog2(N_CH)  source channel of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-014 SHALL implement a two-state FSM, EMPTY and FULL; out_valid = (state == FULL).
REQ-015 SHALL treat the output register as "free" in EMPTY, or in FULL when out_ready=1.
REQ-016 SHALL, while the register is free, grant exactly one eligible channel combinationally; when the register is not free, in_ready SHALL be all-zero.
REQ-017 SHALL, in fixed mode, make only channel sel eligible; a sel value >= N_CH SHALL make no channel eligible.
REQ-018 SHALL, in round-robin mode, grant the first valid channel found searching upward from (ptr+1) mod N_CH, wrapping past N_CH-1 to 0.
REQ-019 SHALL, on a grant, set ptr to the granted index on the same clock edge that loads the data.
REQ-020 SHALL leave ptr unchanged in fixed mode and on cycles with no grant.
REQ-021 SHALL have a latency of 1 cycle: data granted in cycle t appears on out_data/out_ch in cycle t+1.
REQ-022 SHALL, in FULL with out_ready=0, hold out_data and out_ch stable and drive in_ready to zero (backpressure).
REQ-023 SHALL, in FULL with out_ready=1 and a grant in the same cycle, reload the register and stay FULL, sustaining 1 transfer/cycle.
REQ-024 SHALL, in FULL with out_ready=1 and no grant, go to EMPTY.
REQ-025 SHALL apply a mode or sel change on the next grant decision; data already in the register SHALL be unaffected.

Reset
REQ-026 SHALL, when reset=1, set state=EMPTY, out_valid=0, out_data=0, out_ch=0 and ptr=N_CH-1 on the next clock edge, so that channel 0 has first priority.
REQ-027 SHALL hold in_ready all-zero while reset=1, and SHALL discard data held in the register when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, when macro RR_MUX_XFER_CNT_EN is defined, add port xfer_cnt  output  16, which counts output transfers, saturates at 16'hFFFF and is cleared by reset.
REQ-029 SHALL, when RR_MUX_XFER_CNT_EN is undefined, omit the xfer_cnt port and its counter; all other behaviour is identical.

Structure
REQ-030 SHALL place the FSM state enum (EMPTY, FULL) and the default parameter constants in package rr_mux_pkg.
REQ-031 SHALL implement the rotating-priority search as sub-module rr_arbiter (inputs: request vector, ptr, enable; output: one-hot grant), instantiated once.

Verification
REQ-032 SHALL cover: after reset, mode=1, all in_valid=1, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with out_valid=1 from cycle 2.
REQ-033 SHALL cover: mode=0, sel=2, in_valid=4'b1111, in_data ch2=8'hA5 -> in_ready=4'b0100, and next cycle out_data=8'hA5, out_ch=2.
REQ-034 SHALL cover: FULL with out_data=8'h3C, out_ready=0 for 5 cycles -> out_data stays 8'h3C and in_ready=0 throughout.
REQ-035 SHALL cover: mode=1, ptr=3, only in_valid[1]=1 -> grant goes to channel 1 (wrap-around), after which ptr=1.
REQ-036 SHALL cover: reset asserted while FULL -> next cycle out_valid=0, out_data=0, and the following grant goes to channel 0.
REQ-037 SHALL cover, with RR_MUX_XFER_CNT_EN defined: 70000 back-to-back transfers -> xfer_cnt=16'hFFFF.
